cpu_ahb_bridge: RTL

Downstream of the CAN register sequencer. Converts its simple cpu_cs/cpu_read/cpu_write request bus into single AHB-Lite master transfers toward the CAN controller's AHB register slave. Returns a one-cycle cpu_ack, with cpu_err and cpu_rdat, per request. One outstanding transfer; 32-bit word accesses only; includes a data-phase hang timeout.

---
 rtl/cpu_bus_pkg.sv | 51 +++++
 rtl/cpu_ahb_bridge.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/cpu_bus_pkg.sv
// -----------------------------------------------------------------------------
// cpu_bus_pkg
//   Shared definitions for the CPU request bus to AHB-Lite bridge and the CAN
//   register sequencer that drives it.
//   - AHB-Lite constants used by the bridge (transfer type, size, burst, prot)
//   - bridge FSM state type
//   - CAN controller register address map (byte offsets, word aligned)
//   - request legality helper
// -----------------------------------------------------------------------------
package cpu_bus_pkg;

    // AHB-Lite encodings. The bridge only ever issues single word transfers.
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0] HSIZE_WORD    = 3'b010;
    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [3:0] HPROT_DEFAULT = 4'b0011;

    // Bridge FSM states.
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_DONE
    } bridge_state_e;

    // CAN controller register map.
    localparam logic [31:0] CAN_REG_MODE     = 32'h0000_0000;
    localparam logic [31:0] CAN_REG_CMD      = 32'h0000_0004;
    localparam logic [31:0] CAN_REG_BTR      = 32'h0000_0008;
    localparam logic [31:0] CAN_REG_IRQ_EN   = 32'h0000_000C;
    localparam logic [31:0] CAN_REG_STATUS   = 32'h0000_0010;
    localparam logic [31:0] CAN_REG_RX_CTRL  = 32'h0000_0040;
    localparam logic [31:0] CAN_REG_RX_ID    = 32'h0000_0044;
    localparam logic [31:0] CAN_REG_RX_DATA0 = 32'h0000_0048;
    localparam logic [31:0] CAN_REG_RX_DATA1 = 32'h0000_004C;
    localparam logic [31:0] CAN_REG_TX_CTRL  = 32'h0000_0100;
    localparam logic [31:0] CAN_REG_TX_ID    = 32'h0000_0104;
    localparam logic [31:0] CAN_REG_TX_DATA0 = 32'h0000_0108;
    localparam logic [31:0] CAN_REG_TX_DATA1 = 32'h0000_010C;
    localparam logic [31:0] CAN_REG_FILTER   = 32'h0000_0200;

    // A request is legal when exactly one direction is set and the byte
    // address is word aligned.
    function automatic logic req_is_legal(input logic        rd,
                                          input logic        wr,
                                          input logic [31:0] addr);
        return (rd ^ wr) && (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/cpu_ahb_bridge.sv
// -----------------------------------------------------------------------------
// cpu_ahb_bridge
//   Converts single cpu_cs/cpu_read/cpu_write requests into single AHB-Lite
//   word transfers. One transfer outstanding at a time; every request is
//   completed by a one-cycle cpu_ack with cpu_err. A data phase that keeps
//   hready low for TIMEOUT_CYCLES cycles is completed with an error.
//
// Parameters
//   TIMEOUT_CYCLES  data-phase hready-low cycles before forced error (0 = off)
//   CNT_W           timeout counter width, 2**CNT_W > TIMEOUT_CYCLES
//
// Ports
//   hclk, rstn      clock, asynchronous active-low reset
//   cpu_cs          request valid, held until cpu_ack
//   cpu_read/write  request direction (exactly one must be set)
//   cpu_addr/wdat   byte address / write data, stable while cpu_cs is high
//   cpu_rdat        last successfully read data, updated with cpu_ack
//   cpu_ack/err     one-cycle completion pulse and its error qualifier
//   haddr..hprot    AHB-Lite master address/control outputs (registered)
//   hwdata          AHB-Lite write data
//   hrdata/hready/hresp  AHB-Lite slave response inputs
//   busy            high whenever the FSM is not in IDLE
// -----------------------------------------------------------------------------
module cpu_ahb_bridge
    import cpu_bus_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CNT_W          = 8
) (
    input  logic        hclk,
    input  logic        rstn,
    input  logic        cpu_cs,
    input  logic        cpu_read,
    input  logic        cpu_write,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdat,
    output logic [31:0] cpu_rdat,
    output logic        cpu_ack,
    output logic        cpu_err,
    output logic [31:0] haddr,
    output logic [1:0]  htrans,
    output logic        hwrite,
    output logic [2:0]  hsize,
    output logic [2:0]  hburst,
    output logic [3:0]  hprot,
    output logic [31:0] hwdata,
    input  logic [31:0] hrdata,
    input  logic        hready,
    input  logic        hresp,
    output logic        busy
);

    localparam logic [CNT_W:0] TIMEOUT_LIM = (CNT_W + 1)'(TIMEOUT_CYCLES);
    localparam logic [CNT_W:0] CNT_ONE     = (CNT_W + 1)'(1);

    bridge_state_e    state_q;
    logic             cs_q;
    logic             armed_q;
    logic [31:0]      haddr_q;
    logic [1:0]       htrans_q;
    logic             hwrite_q;
    logic [31:0]      wdat_q;
    logic [31:0]      hwdata_q;
    logic [31:0]      rdat_q;
    logic             ack_q;
    logic             err_q;
    logic             busy_q;
    logic [CNT_W-1:0] cnt_q;

    logic [CNT_W:0]   cnt_d;
    logic             timeout_hit;

    // Counter value after this data-phase wait cycle; one extra bit so the
    // comparison against the limit can never alias on wrap.
    always_comb begin
        cnt_d       = {1'b0, cnt_q} + CNT_ONE;
        timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_d == TIMEOUT_LIM);
    end

    // cs is sampled into cs_q and the FSM acts on the sampled value. armed_q
    // is set only after IDLE has seen cs low, so a cs that is still high (or
    // still sampled high) right after an ack cannot replay the request.
    always_ff @(posedge hclk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= ST_IDLE;
            cs_q     <= 1'b0;
            armed_q  <= 1'b1;
            haddr_q  <= '0;
            htrans_q <= HTRANS_IDLE;
            hwrite_q <= 1'b0;
            wdat_q   <= '0;
            hwdata_q <= '0;
            rdat_q   <= '0;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            cs_q  <= cpu_cs;
            ack_q <= 1'b0;
            err_q <= 1'b0;

            unique case (state_q)
                ST_IDLE: begin
                    if (!cs_q) begin
                        armed_q <= 1'b1;
                    end else if (armed_q) begin
                        armed_q <= 1'b0;
                        busy_q  <= 1'b1;
                        if (req_is_legal(cpu_read, cpu_write, cpu_addr)) begin
                            haddr_q  <= cpu_addr;
                            hwrite_q <= cpu_write;
                            wdat_q   <= cpu_wdat;
                            htrans_q <= HTRANS_NONSEQ;
                            state_q  <= ST_ADDR;
                        end else begin
                            // Rejected without touching the bus.
                            ack_q   <= 1'b1;
                            err_q   <= 1'b1;
                            state_q <= ST_DONE;
                        end
                    end
                end

                ST_ADDR: begin
                    if (hready) begin
                        htrans_q <= HTRANS_IDLE;
                        if (hwrite_q) begin
                            hwdata_q <= wdat_q;
                        end
                        cnt_q   <= '0;
                        state_q <= ST_DATA;
                    end
                end

                ST_DATA: begin
                    if (hready) begin
                        ack_q <= 1'b1;
                        err_q <= hresp;
                        if (!hresp && !hwrite_q) begin
                            rdat_q <= hrdata;
                        end
                        state_q <= ST_DONE;
                    end else begin
                        // hresp=1 here is the first half of an ERROR response;
                        // it is treated like any other wait cycle.
                        cnt_q <= cnt_d[CNT_W-1:0];
                        if (timeout_hit) begin
                            ack_q   <= 1'b1;
                            err_q   <= 1'b1;
                            state_q <= ST_DONE;
                        end
                    end
                end

                ST_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end

                default: begin
                    htrans_q <= HTRANS_IDLE;
                    busy_q   <= 1'b0;
                    state_q  <= ST_IDLE;
                end
            endcase
        end
    end

    assign cpu_rdat = rdat_q;
    assign cpu_ack  = ack_q;
    assign cpu_err  = err_q;
    assign haddr    = haddr_q;
    assign htrans   = htrans_q;
    assign hwrite   = hwrite_q;
    assign hsize    = HSIZE_WORD;
    assign hburst   = HBURST_SINGLE;
    assign hprot    = HPROT_DEFAULT;
    assign hwdata   = hwdata_q;
    assign busy     = busy_q;

endmodule
